// File: rtl/hazard_tracker_pkg.sv
// hazard_tracker_pkg: shared widths, stage-tag type and bubble constant. Rev 1.0
`default_nettype none

package hazard_tracker_pkg;

  localparam int REG_W = 4;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic             wb_en;
    logic             mem_r_en;
  } stage_tag_t;

  localparam stage_tag_t BUBBLE_TAG = '{dest: '0, wb_en: 1'b0, mem_r_en: 1'b0};

endpackage

`default_nettype wire

// File: rtl/hazard_compare.sv
// hazard_compare: ID source vs EXE/MEM destination matching. FORWARDING_EN limits stalls to load-use. Rev 1.0
`default_nettype none

module hazard_compare
  import hazard_tracker_pkg::*;
(
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  output logic             hazard
);

  logic match1_exe, match2_exe, match1_mem, match2_mem;

  always_comb begin
    match1_exe = exe_wb_en & (id_src1 == exe_dest);
    match2_exe = exe_wb_en & id_two_src & (id_src2 == exe_dest);
    match1_mem = mem_wb_en & (id_src1 == mem_dest);
    match2_mem = mem_wb_en & id_two_src & (id_src2 == mem_dest);
  end

`ifdef FORWARDING_EN
  // Only a load in EXE cannot be forwarded in time.
  logic unused_mem_match;
  assign unused_mem_match = match1_mem | match2_mem;
  assign hazard = id_valid & exe_mem_r_en & (match1_exe | match2_exe);
`else
  logic unused_exe_ld;
  assign unused_exe_ld = exe_mem_r_en;
  assign hazard = id_valid & (match1_exe | match2_exe | match1_mem | match2_mem);
`endif

endmodule

`default_nettype wire

// File: rtl/hazard_tracker.sv
// hazard_tracker: EXE/MEM/WB destination tags plus saturating stall counter; FORWARDING_EN via hazard_compare. Rev 1.0
`default_nettype none

module hazard_tracker
  import hazard_tracker_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_valid,
  input  logic [REG_W-1:0] ID_src1,
  input  logic [REG_W-1:0] ID_src2,
  input  logic             ID_two_src,
  input  logic [REG_W-1:0] ID_Dest,
  input  logic             ID_WB_en,
  input  logic             ID_MEM_R_en,
  input  logic             freeze,
  input  logic             flush,
  output logic [REG_W-1:0] EXE_Dest,
  output logic [REG_W-1:0] MEM_Dest,
  output logic [REG_W-1:0] WB_Dest,
  output logic             EXE_WB_en,
  output logic             MEM_WB_en,
  output logic             WB_WB_en,
  output logic             EXE_MEM_R_en,
  output logic             hazard_detected,
  output logic [CNT_W-1:0] stall_count
);

  stage_tag_t       exe_q, exe_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             hazard;

  hazard_compare u_hazard_compare (
    .id_valid     (ID_valid),
    .id_src1      (ID_src1),
    .id_src2      (ID_src2),
    .id_two_src   (ID_two_src),
    .exe_dest     (exe_q.dest),
    .exe_wb_en    (exe_q.wb_en),
    .exe_mem_r_en (exe_q.mem_r_en),
    .mem_dest     (mem_q.dest),
    .mem_wb_en    (mem_q.wb_en),
    .hazard       (hazard)
  );

  always_comb begin
    exe_d         = exe_q;
    mem_d         = mem_q;
    wb_d          = wb_q;
    stall_count_d = stall_count_q;
    if (!freeze) begin
      wb_d  = mem_q;
      mem_d = exe_q;
      if (ID_valid && !hazard && !flush)
        exe_d = '{dest: ID_Dest, wb_en: ID_WB_en, mem_r_en: ID_MEM_R_en};
      else
        exe_d = BUBBLE_TAG;
      // A flushed instruction never issues, so its stall is not counted.
      if (hazard && !flush && (stall_count_q != {CNT_W{1'b1}}))
        stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q         <= BUBBLE_TAG;
      mem_q         <= BUBBLE_TAG;
      wb_q          <= BUBBLE_TAG;
      stall_count_q <= '0;
    end else begin
      exe_q         <= exe_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      stall_count_q <= stall_count_d;
    end
  end

  logic unused_wb_ld;
  assign unused_wb_ld = wb_q.mem_r_en;

  assign EXE_Dest        = exe_q.dest;
  assign MEM_Dest        = mem_q.dest;
  assign WB_Dest         = wb_q.dest;
  assign EXE_WB_en       = exe_q.wb_en;
  assign MEM_WB_en       = mem_q.wb_en;
  assign WB_WB_en        = wb_q.wb_en;
  assign EXE_MEM_R_en    = exe_q.mem_r_en;
  assign hazard_detected = hazard;
  assign stall_count     = stall_count_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker: vector table, directed corner sequences and random stimulus against a pipeline model.
`default_nettype none

module tb_hazard_tracker;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       ID_valid;
  logic [3:0] ID_src1, ID_src2, ID_Dest;
  logic       ID_two_src, ID_WB_en, ID_MEM_R_en;
  logic       freeze, flush;
  logic [3:0] EXE_Dest, MEM_Dest, WB_Dest;
  logic       EXE_WB_en, MEM_WB_en, WB_WB_en, EXE_MEM_R_en;
  logic       hazard_detected;
  logic [15:0] stall_count;

  hazard_tracker dut (
    .clk             (clk),
    .rst             (rst),
    .ID_valid        (ID_valid),
    .ID_src1         (ID_src1),
    .ID_src2         (ID_src2),
    .ID_two_src      (ID_two_src),
    .ID_Dest         (ID_Dest),
    .ID_WB_en        (ID_WB_en),
    .ID_MEM_R_en     (ID_MEM_R_en),
    .freeze          (freeze),
    .flush           (flush),
    .EXE_Dest        (EXE_Dest),
    .MEM_Dest        (MEM_Dest),
    .WB_Dest         (WB_Dest),
    .EXE_WB_en       (EXE_WB_en),
    .MEM_WB_en       (MEM_WB_en),
    .WB_WB_en        (WB_WB_en),
    .EXE_MEM_R_en    (EXE_MEM_R_en),
    .hazard_detected (hazard_detected),
    .stall_count     (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: index 0 = EXE, 1 = MEM, 2 = WB.
  typedef struct packed {
    logic [3:0] dest;
    logic       wb;
    logic       ld;
  } mtag_t;

  mtag_t m_pipe [3];
  int    m_cnt;
  logic  hz_seen;

  function automatic bit model_hz(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                                  input logic two);
    bit h = 1'b0;
    int last = FWD ? 0 : 1;
    if (!v) return 1'b0;
    for (int k = 0; k <= last; k++) begin
      if (m_pipe[k].wb && (s1 == m_pipe[k].dest || (two && s2 == m_pipe[k].dest))) begin
        if (!FWD || m_pipe[k].ld) h = 1'b1;
      end
    end
    return h;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) m_pipe[k] = '0;
    m_cnt = 0;
  endtask

  // Drive one cycle, compare pre-edge outputs with the model, then advance both.
  task automatic step(input logic r, input logic v, input logic [3:0] s1, input logic [3:0] s2,
                      input logic two, input logic [3:0] d, input logic wb, input logic ld,
                      input logic fz, input logic fl);
    bit h;
    rst = r; ID_valid = v; ID_src1 = s1; ID_src2 = s2; ID_two_src = two;
    ID_Dest = d; ID_WB_en = wb; ID_MEM_R_en = ld; freeze = fz; flush = fl;
    #2;
    h = model_hz(v, s1, s2, two);
    hz_seen = hazard_detected;
    check("hazard", 32'(hazard_detected), 32'(h));
    check("exe_dest", 32'(EXE_Dest), 32'(m_pipe[0].dest));
    check("exe_wb", 32'(EXE_WB_en), 32'(m_pipe[0].wb));
    check("exe_ld", 32'(EXE_MEM_R_en), 32'(m_pipe[0].ld));
    check("mem_dest", 32'(MEM_Dest), 32'(m_pipe[1].dest));
    check("mem_wb", 32'(MEM_WB_en), 32'(m_pipe[1].wb));
    check("wb_dest", 32'(WB_Dest), 32'(m_pipe[2].dest));
    check("wb_wb", 32'(WB_WB_en), 32'(m_pipe[2].wb));
    check("stall_count", 32'(stall_count), 32'(m_cnt));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (!fz) begin
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = (v && !h && !fl) ? mtag_t'{d, wb, ld} : mtag_t'(0);
      if (h && !fl && m_cnt < 65535) m_cnt++;
    end
    #1;
  endtask

  typedef struct packed {
    logic r, v;
    logic [3:0] s1, s2;
    logic two;
    logic [3:0] d;
    logic wb, ld, fz, fl;
    logic hz;
    logic [3:0] e_dest;
    logic e_wb, e_ld;
    logic [15:0] cnt;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          r    v    s1   s2   two  d    wb   ld   fz   fl   hz              e_dest            e_wb            e_ld cnt
    vecs[0]  = '{1'b0,1'b1,4'd1,4'd2,1'b1,4'd3,1'b1,1'b1,1'b0,1'b0, 1'b0,           4'd3,             1'b1,           1'b1,16'd0};
    vecs[1]  = '{1'b0,1'b1,4'd3,4'd0,1'b0,4'd4,1'b1,1'b0,1'b0,1'b0, 1'b1,           4'd0,             1'b0,           1'b0,16'd1};
    vecs[2]  = '{1'b0,1'b1,4'd3,4'd0,1'b0,4'd4,1'b1,1'b0,1'b0,1'b0, FWD?1'b0:1'b1,  FWD?4'd4:4'd0,    FWD?1'b1:1'b0,  1'b0,FWD?16'd1:16'd2};
    vecs[3]  = '{1'b1,1'b0,4'd0,4'd0,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0, 1'b0,           4'd0,             1'b0,           1'b0,16'd0};
    vecs[4]  = '{1'b0,1'b1,4'd1,4'd2,1'b1,4'd5,1'b1,1'b0,1'b0,1'b0, 1'b0,           4'd5,             1'b1,           1'b0,16'd0};
    vecs[5]  = '{1'b0,1'b1,4'd9,4'd5,1'b1,4'd6,1'b1,1'b0,1'b0,1'b0, FWD?1'b0:1'b1,  FWD?4'd6:4'd0,    FWD?1'b1:1'b0,  1'b0,FWD?16'd0:16'd1};
    vecs[6]  = '{1'b1,1'b0,4'd0,4'd0,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0, 1'b0,           4'd0,             1'b0,           1'b0,16'd0};
    vecs[7]  = '{1'b0,1'b1,4'd1,4'd1,1'b0,4'd7,1'b1,1'b0,1'b0,1'b0, 1'b0,           4'd7,             1'b1,           1'b0,16'd0};
    vecs[8]  = '{1'b0,1'b0,4'd7,4'd0,1'b0,4'd8,1'b1,1'b0,1'b0,1'b0, 1'b0,           4'd0,             1'b0,           1'b0,16'd0};
    vecs[9]  = '{1'b0,1'b1,4'd7,4'd0,1'b0,4'd8,1'b1,1'b0,1'b0,1'b0, FWD?1'b0:1'b1,  FWD?4'd8:4'd0,    FWD?1'b1:1'b0,  1'b0,FWD?16'd0:16'd1};
    vecs[10] = '{1'b1,1'b0,4'd0,4'd0,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0, 1'b0,           4'd0,             1'b0,           1'b0,16'd0};
    vecs[11] = '{1'b0,1'b1,4'd0,4'd0,1'b0,4'd0,1'b1,1'b1,1'b0,1'b0, 1'b0,           4'd0,             1'b1,           1'b1,16'd0};
    vecs[12] = '{1'b0,1'b1,4'd0,4'd0,1'b0,4'd2,1'b1,1'b0,1'b0,1'b1, 1'b1,           4'd0,             1'b0,           1'b0,16'd0};
    vecs[13] = '{1'b0,1'b1,4'd5,4'd0,1'b0,4'd2,1'b1,1'b0,1'b0,1'b0, 1'b0,           4'd2,             1'b1,           1'b0,16'd0};
    vecs[14] = '{1'b0,1'b1,4'd6,4'd2,1'b0,4'd3,1'b0,1'b0,1'b0,1'b0, 1'b0,           4'd3,             1'b0,           1'b0,16'd0};
    vecs[15] = '{1'b0,1'b1,4'd3,4'd3,1'b1,4'd9,1'b1,1'b0,1'b0,1'b0, 1'b0,           4'd9,             1'b1,           1'b0,16'd0};
    vecs[16] = '{1'b0,1'b1,4'd9,4'd0,1'b0,4'd1,1'b1,1'b1,1'b1,1'b0, FWD?1'b0:1'b1,  4'd9,             1'b1,           1'b0,16'd0};

    rst = 1'b1; ID_valid = 1'b0; ID_src1 = '0; ID_src2 = '0; ID_two_src = 1'b0;
    ID_Dest = '0; ID_WB_en = 1'b0; ID_MEM_R_en = 1'b0; freeze = 1'b0; flush = 1'b0;
    hz_seen = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; ID_valid = 1'b1;
    #1;
    check("reset_hazard", 32'(hazard_detected), 32'd0);
    check("reset_exe_dest", 32'(EXE_Dest), 32'd0);
    check("reset_count", 32'(stall_count), 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].r, vecs[i].v, vecs[i].s1, vecs[i].s2, vecs[i].two, vecs[i].d,
           vecs[i].wb, vecs[i].ld, vecs[i].fz, vecs[i].fl);
      check($sformatf("vec%0d_hz", i), 32'(hz_seen), 32'(vecs[i].hz));
      check($sformatf("vec%0d_exe_dest", i), 32'(EXE_Dest), 32'(vecs[i].e_dest));
      check($sformatf("vec%0d_exe_wb", i), 32'(EXE_WB_en), 32'(vecs[i].e_wb));
      check($sformatf("vec%0d_exe_ld", i), 32'(EXE_MEM_R_en), 32'(vecs[i].e_ld));
      check($sformatf("vec%0d_cnt", i), 32'(stall_count), 32'(vecs[i].cnt));
    end

    // Freeze with three distinct tags resident, then release.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 15, 15, 0, 10, 1, 0, 0, 0);
    step(0, 1, 15, 15, 0, 11, 1, 0, 0, 0);
    step(0, 1, 15, 15, 0, 12, 1, 0, 0, 0);
    repeat (3) step(0, 1, 10, 11, 1, 1, 1, 0, 1, 0);
    check("frz_exe", 32'(EXE_Dest), 32'd12);
    check("frz_mem", 32'(MEM_Dest), 32'd11);
    check("frz_wb", 32'(WB_Dest), 32'd10);
    check("frz_cnt", 32'(stall_count), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rel_wb", 32'(WB_Dest), 32'd11);
    check("rel_mem", 32'(MEM_Dest), 32'd12);
    check("rel_exe_wb", 32'(EXE_WB_en), 32'd0);

    // Saturation from a preloaded count, then reset mid-run.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    force dut.stall_count_q = 16'hFFFE;
    m_cnt = 16'hFFFE;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    release dut.stall_count_q;
    step(0, 1, 15, 15, 0, 1, 1, 1, 0, 0);
    repeat (6) step(0, 1, 1, 1, 0, 1, 1, 1, 0, 0);
    check("sat_cnt", 32'(stall_count), 32'hFFFF);
    step(1, 1, 1, 1, 0, 1, 1, 1, 0, 0);
    check("midrst_exe_wb", 32'(EXE_WB_en), 32'd0);
    check("midrst_mem_wb", 32'(MEM_WB_en), 32'd0);
    check("midrst_wb_wb", 32'(WB_WB_en), 32'd0);
    check("midrst_cnt", 32'(stall_count), 32'd0);
    check("midrst_hazard", 32'(hazard_detected), 32'd0);

    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(63) == 0, $urandom_range(7) != 0,
           4'($urandom_range(3)), 4'($urandom_range(3)), 1'($urandom_range(1)),
           4'($urandom_range(3)), $urandom_range(3) != 0, 1'($urandom_range(1)),
           $urandom_range(7) == 0, $urandom_range(7) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
